// File: rtl/hog_svm_pkg.sv
// Shared constants, loader state encoding and bank-pointer helper for the SVM coefficient store.
package hog_svm_pkg;

  localparam int unsigned COEF_W = 12;
  localparam int unsigned N_COEF = 105;
  localparam int unsigned N_ROW  = 36;
  localparam int unsigned N_BANK = 2;
  localparam int unsigned HOST_W = 32;

  localparam int unsigned RAM_DW    = COEF_W * N_COEF;
  localparam int unsigned WPR       = (RAM_DW + HOST_W - 1) / HOST_W;
  localparam int unsigned ACC_W     = WPR * HOST_W;
  localparam int unsigned ADDR_W    = $clog2(N_ROW);
  localparam int unsigned BANK_W    = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int unsigned WC_W      = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int unsigned RAM_AW    = BANK_W + ADDR_W;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    PEND
  } ldr_state_e;

  // Bank that follows b in round-robin order.
  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == BANK_W'(N_BANK - 1)) ? '0 : b + BANK_W'(1);
  endfunction

endpackage

// File: rtl/coef_bank_ram.sv
// Simple dual-port coefficient RAM addressed as {bank,row}, registered read that holds when idle.
module coef_bank_ram
  import hog_svm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [RAM_DW-1:0] wdata,
  input  logic              re,
  input  logic [RAM_AW-1:0] raddr,
  output logic [RAM_DW-1:0] rdata
);

  // Depth covers the full {bank,row} space so the concatenated address indexes directly.
  logic [RAM_DW-1:0] mem [RAM_DEPTH];

  // Write port: one full row per write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: one-cycle latency, output register holds its value when re is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/svm_coef_bank_loader.sv
// Packs host words into coefficient rows, fills a shadow bank and swaps it active on a frame boundary.
module svm_coef_bank_loader
  import hog_svm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic [HOST_W-1:0] h_data,
  input  logic              b_load,
  input  logic [COEF_W-1:0] bias,
  input  logic              commit,
  input  logic              frame_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [RAM_DW-1:0] rd_data,
  output logic [COEF_W-1:0] bias_out,
  output logic [BANK_W-1:0] active_bank,
  output logic              load_done,
  output logic              swapped,
  output logic              err_ovf
);

  ldr_state_e        state_q, state_d;
  logic [WC_W-1:0]   word_cnt_q;
  logic [ADDR_W-1:0] row_cnt_q;
  logic [ADDR_W-1:0] wr_row_q;
  logic              wr_pend_q;
  logic [ACC_W-1:0]  acc_q;
  logic [BANK_W-1:0] shadow_q;
  logic [COEF_W-1:0] shadow_bias_q;

  logic restart_c, accept_c, row_end_c, swap_c, bias_wr_c, err_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d   = state_q;
    restart_c = 1'b0;
    accept_c  = 1'b0;
    row_end_c = 1'b0;
    swap_c    = 1'b0;
    bias_wr_c = 1'b0;
    err_c     = h_valid & ~h_ready;
    case (state_q)
      IDLE: begin
        bias_wr_c = b_load;
        if (load_start) begin
          restart_c = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        bias_wr_c = b_load;
        if (load_start) begin
          restart_c = 1'b1;
        end else if (h_valid) begin
          accept_c  = 1'b1;
          row_end_c = (word_cnt_q == WC_W'(WPR - 1));
          if (row_end_c && (row_cnt_q == ADDR_W'(N_ROW - 1))) state_d = DONE;
        end
      end
      DONE: begin
        bias_wr_c = b_load;
        if (commit) begin
          if (frame_done) begin
            swap_c  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (load_start || b_load) err_c = 1'b1;
        if (frame_done) begin
          swap_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: packing, counters, deferred row write, bias and bank swap, status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_ready       <= 1'b0;
      word_cnt_q    <= '0;
      row_cnt_q     <= '0;
      wr_row_q      <= '0;
      wr_pend_q     <= 1'b0;
      acc_q         <= '0;
      shadow_q      <= '0;
      shadow_bias_q <= '0;
      bias_out      <= '0;
      active_bank   <= '0;
      load_done     <= 1'b0;
      swapped       <= 1'b0;
      err_ovf       <= 1'b0;
    end else begin
      h_ready   <= (state_d == LOAD);
      wr_pend_q <= 1'b0;
      swapped   <= 1'b0;
      load_done <= wr_pend_q && (wr_row_q == ADDR_W'(N_ROW - 1));
      if (restart_c) begin
        word_cnt_q <= '0;
        row_cnt_q  <= '0;
        acc_q      <= '0;
        shadow_q   <= next_bank(active_bank);
      end else if (accept_c) begin
        // Newest word enters at the top; after WPR words word 0 sits in bits [HOST_W-1:0].
        acc_q <= {h_data, acc_q[ACC_W-1:HOST_W]};
        if (row_end_c) begin
          word_cnt_q <= '0;
          row_cnt_q  <= row_cnt_q + ADDR_W'(1);
          wr_row_q   <= row_cnt_q;
          wr_pend_q  <= 1'b1;
        end else begin
          word_cnt_q <= word_cnt_q + WC_W'(1);
        end
      end
      if (bias_wr_c) shadow_bias_q <= bias;
      if (swap_c) begin
        active_bank <= shadow_q;
        bias_out    <= shadow_bias_q;
        swapped     <= 1'b1;
      end
      if (err_c) err_ovf <= 1'b1;
    end
  end

  // Shadow writes and classifier reads always target different banks.
  coef_bank_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_pend_q),
    .waddr ({shadow_q, wr_row_q}),
    .wdata (acc_q[RAM_DW-1:0]),
    .re    (rd_en),
    .raddr ({active_bank, rd_addr}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_svm_coef_bank_loader.sv
// Randomized bench for svm_coef_bank_loader against a row/bank-level reference model.
module tb_svm_coef_bank_loader;
  import hog_svm_pkg::*;

  logic              clk;
  logic              rst;
  logic              load_start;
  logic              h_valid;
  logic              h_ready;
  logic [HOST_W-1:0] h_data;
  logic              b_load;
  logic [COEF_W-1:0] bias;
  logic              commit;
  logic              frame_done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [RAM_DW-1:0] rd_data;
  logic [COEF_W-1:0] bias_out;
  logic [BANK_W-1:0] active_bank;
  logic              load_done;
  logic              swapped;
  logic              err_ovf;

  svm_coef_bank_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .h_valid     (h_valid),
    .h_ready     (h_ready),
    .h_data      (h_data),
    .b_load      (b_load),
    .bias        (bias),
    .commit      (commit),
    .frame_done  (frame_done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .bias_out    (bias_out),
    .active_bank (active_bank),
    .load_done   (load_done),
    .swapped     (swapped),
    .err_ovf     (err_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ld_cnt   = 0;
  int sw_cnt   = 0;
  int wr_idx   = 0;

  // Reference model: host words of the current load, per-bank row contents, bank/bias state.
  logic [HOST_W-1:0] cur_words [N_ROW*WPR];
  logic [RAM_DW-1:0] model_mem [N_BANK][N_ROW];
  int                model_act;
  logic [COEF_W-1:0] model_sh_bias;
  logic [COEF_W-1:0] model_act_bias;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (load_done === 1'b1) ld_cnt++;
    if (swapped === 1'b1)   sw_cnt++;
  end

  task automatic chk(input string tag, input logic [RAM_DW-1:0] obs, input logic [RAM_DW-1:0] exp);
    logic [ACC_W-1:0] o;
    logic [ACC_W-1:0] e;
    int w;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      o = ACC_W'(obs);
      e = ACC_W'(exp);
      w = 0;
      for (int i = WPR - 1; i >= 0; i--)
        if (o[i*HOST_W +: HOST_W] !== e[i*HOST_W +: HOST_W]) w = i;
      $display("FAIL %s: word %0d got %h expected %h", tag, w,
               o[w*HOST_W +: HOST_W], e[w*HOST_W +: HOST_W]);
    end
  endtask

  // Row r of the current load: word k of the row lands at bit offset k*HOST_W.
  function automatic logic [RAM_DW-1:0] pack_row(input int r);
    logic [ACC_W-1:0] t;
    t = '0;
    for (int k = 0; k < WPR; k++) t[k*HOST_W +: HOST_W] = cur_words[r*WPR + k];
    return t[RAM_DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_ROW*WPR; i++) cur_words[i] = HOST_W'($urandom);
    wr_idx = 0;
  endtask

  task automatic store_model(input int bank);
    for (int r = 0; r < N_ROW; r++) model_mem[bank][r] = pack_row(r);
  endtask

  // Offer n words with random gaps; optionally read random rows of the active bank every cycle.
  task automatic send_words(input int n, input bit rd_bg, input string tag);
    int got = 0;
    int cyc = 0;
    bit acc;
    while (got < n && cyc < 20*n + 100) begin
      h_valid = ($urandom_range(3) != 0);
      h_data  = cur_words[wr_idx];
      if (rd_bg) begin
        rd_en   = 1'b1;
        rd_addr = ADDR_W'($urandom_range(N_ROW - 1));
      end
      acc = h_valid && h_ready;
      tick();
      if (acc) begin
        got++;
        wr_idx++;
      end
      if (rd_bg) chk({tag, "_bg_read"}, rd_data, model_mem[model_act][int'(rd_addr)]);
      cyc++;
    end
    h_valid = 1'b0;
    rd_en   = 1'b0;
    if (got < n) chk({tag, "_send_timeout"}, RAM_DW'(got), RAM_DW'(n));
  endtask

  task automatic wait_load_done(input string tag);
    int start = ld_cnt;
    for (int c = 0; c < 20 && ld_cnt == start; c++) tick();
    repeat (3) tick();
    chk(tag, RAM_DW'(ld_cnt - start), RAM_DW'(1));
  endtask

  task automatic read_row(input int r, input string tag);
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(r);
    tick();
    rd_en = 1'b0;
    chk(tag, rd_data, model_mem[model_act][r]);
  endtask

  task automatic apply_swap();
    model_act      = (model_act + 1) % N_BANK;
    model_act_bias = model_sh_bias;
  endtask

  initial begin
    int sw0;
    clk = 1'b0; rst = 1'b1; load_start = 1'b0; h_valid = 1'b0; h_data = '0;
    b_load = 1'b0; bias = '0; commit = 1'b0; frame_done = 1'b0; rd_en = 1'b0; rd_addr = '0;
    model_act = 0; model_sh_bias = '0; model_act_bias = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Reset state.
    chk("rst_h_ready",     RAM_DW'(h_ready),     RAM_DW'(0));
    chk("rst_active_bank", RAM_DW'(active_bank), RAM_DW'(0));
    chk("rst_bias_out",    RAM_DW'(bias_out),    RAM_DW'(0));
    chk("rst_err_ovf",     RAM_DW'(err_ovf),     RAM_DW'(0));
    chk("rst_flags",       RAM_DW'({load_done, swapped}), RAM_DW'(0));
    chk("rst_rd_data",     rd_data,              RAM_DW'(0));

    // T1: full load with word value = index, bias 0x0A5, commit then frame_done.
    for (int i = 0; i < N_ROW*WPR; i++) cur_words[i] = HOST_W'(i);
    wr_idx = 0;
    pulse_load();
    chk("t1_h_ready_load", RAM_DW'(h_ready), RAM_DW'(1));
    send_words(N_ROW*WPR, 1'b0, "t1");
    wait_load_done("t1_load_done_once");
    store_model(1);
    b_load = 1'b1; bias = 12'h0A5; tick(); b_load = 1'b0;
    model_sh_bias = 12'h0A5;
    sw0 = sw_cnt;
    commit = 1'b1; tick(); commit = 1'b0;
    repeat (3) tick();
    chk("t1_pend_no_swap", RAM_DW'(active_bank), RAM_DW'(0));
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    apply_swap();
    chk("t1_swapped",     RAM_DW'(swapped),     RAM_DW'(1));
    chk("t1_active_bank", RAM_DW'(active_bank), RAM_DW'(1));
    chk("t1_bias_out",    RAM_DW'(bias_out),    RAM_DW'(12'h0A5));
    repeat (3) tick();
    chk("t1_swapped_once", RAM_DW'(sw_cnt - sw0), RAM_DW'(1));
    read_row(3, "t1_row3");
    chk("t1_row3_word0", RAM_DW'(rd_data[HOST_W-1:0]), RAM_DW'(120));
    repeat (2) tick();
    chk("t1_row3_hold", rd_data, model_mem[1][3]);

    // T2: load bank 0 while reading bank 1; read in swap cycle returns old bank.
    fill_random();
    pulse_load();
    send_words(N_ROW*WPR, 1'b1, "t2");
    wait_load_done("t2_load_done");
    store_model(0);
    b_load = 1'b1; bias = COEF_W'($urandom); model_sh_bias = bias; tick(); b_load = 1'b0;
    commit = 1'b1; tick(); commit = 1'b0;
    tick();
    frame_done = 1'b1; rd_en = 1'b1; rd_addr = ADDR_W'(5);
    tick();
    frame_done = 1'b0; rd_en = 1'b0;
    chk("t2_swap_cycle_read_old", rd_data, model_mem[1][5]);
    apply_swap();
    chk("t2_active_bank", RAM_DW'(active_bank), RAM_DW'(0));
    chk("t2_bias_out",    RAM_DW'(bias_out),    RAM_DW'(model_act_bias));
    for (int i = 0; i < 4; i++) read_row($urandom_range(N_ROW - 1), "t2_row");

    // T3: abort after 500 words, full reload, then commit and frame_done together.
    fill_random();
    pulse_load();
    send_words(500, 1'b0, "t3_abort");
    pulse_load();
    fill_random();
    send_words(N_ROW*WPR, 1'b0, "t3");
    wait_load_done("t3_load_done");
    store_model(1);
    commit = 1'b1; frame_done = 1'b1; tick(); commit = 1'b0; frame_done = 1'b0;
    apply_swap();
    chk("t3_swapped_same_cycle", RAM_DW'(swapped),     RAM_DW'(1));
    chk("t3_active_bank",        RAM_DW'(active_bank), RAM_DW'(1));
    read_row(0,  "t3_row0_new_data");
    read_row(11, "t3_row11_new_data");
    read_row(12, "t3_row12_new_data");

    // T4: commit during LOAD is ignored; bias written in LOAD is carried by the swap.
    fill_random();
    pulse_load();
    send_words(100, 1'b0, "t4a");
    commit = 1'b1; frame_done = 1'b1; tick(); commit = 1'b0; frame_done = 1'b0;
    tick();
    chk("t4_load_commit_no_swap", RAM_DW'(swapped),     RAM_DW'(0));
    chk("t4_load_commit_bank",    RAM_DW'(active_bank), RAM_DW'(1));
    chk("t4_still_loading",       RAM_DW'(h_ready),     RAM_DW'(1));
    b_load = 1'b1; bias = COEF_W'($urandom); model_sh_bias = bias; tick(); b_load = 1'b0;
    send_words(N_ROW*WPR - 100, 1'b0, "t4b");
    wait_load_done("t4_load_done");
    store_model(0);
    chk("t4_no_err_yet", RAM_DW'(err_ovf), RAM_DW'(0));
    commit = 1'b1; tick(); commit = 1'b0;
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    apply_swap();
    chk("t4_active_bank", RAM_DW'(active_bank), RAM_DW'(0));
    chk("t4_bias_out",    RAM_DW'(bias_out),    RAM_DW'(model_act_bias));
    read_row($urandom_range(N_ROW - 1), "t4_row");

    // T5: host word offered in IDLE is refused and flags a sticky error.
    h_valid = 1'b1; h_data = HOST_W'($urandom);
    repeat (3) tick();
    h_valid = 1'b0;
    chk("t5_idle_h_ready", RAM_DW'(h_ready), RAM_DW'(0));
    chk("t5_err_set",      RAM_DW'(err_ovf), RAM_DW'(1));
    repeat (4) tick();
    chk("t5_err_sticky",   RAM_DW'(err_ovf), RAM_DW'(1));

    // T6: reset in the middle of a load.
    fill_random();
    pulse_load();
    send_words(700, 1'b0, "t6");
    rst = 1'b1;
    #2;
    chk("t6_async_h_ready", RAM_DW'(h_ready), RAM_DW'(0));
    tick();
    rst = 1'b0;
    tick();
    model_act = 0; model_act_bias = '0; model_sh_bias = '0;
    chk("t6_active_bank", RAM_DW'(active_bank), RAM_DW'(0));
    chk("t6_bias_out",    RAM_DW'(bias_out),    RAM_DW'(0));
    chk("t6_err_cleared", RAM_DW'(err_ovf),     RAM_DW'(0));
    repeat (3) tick();
    chk("t6_idle_h_ready", RAM_DW'(h_ready),    RAM_DW'(0));
    read_row(7, "t6_bank0_intact");

    // T7: load_start and b_load while pending are refused and flag the error.
    fill_random();
    pulse_load();
    send_words(N_ROW*WPR, 1'b0, "t7");
    wait_load_done("t7_load_done");
    store_model(1);
    b_load = 1'b1; bias = COEF_W'($urandom); model_sh_bias = bias; tick(); b_load = 1'b0;
    commit = 1'b1; tick(); commit = 1'b0;
    b_load = 1'b1; bias = ~model_sh_bias; load_start = 1'b1; tick();
    b_load = 1'b0; load_start = 1'b0;
    chk("t7_pend_err",     RAM_DW'(err_ovf), RAM_DW'(1));
    chk("t7_pend_h_ready", RAM_DW'(h_ready), RAM_DW'(0));
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    apply_swap();
    chk("t7_active_bank", RAM_DW'(active_bank), RAM_DW'(1));
    chk("t7_bias_kept",   RAM_DW'(bias_out),    RAM_DW'(model_act_bias));
    read_row(0,         "t7_row_first");
    read_row(N_ROW - 1, "t7_row_last");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
